// File: rtl/xs3_to_bin_seq_pkg.sv
// Shared constants, FSM state type and the result-width helper for the XS3 to binary converter.
package xs3_pkg;

  localparam logic [3:0] XS3_BIAS = 4'd3;
  localparam logic [3:0] XS3_MIN  = 4'd3;
  localparam logic [3:0] XS3_MAX  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } xs3_state_t;

  // Bits needed to hold any n-digit decimal number, i.e. ceil(log2(10**n)).
  function automatic int clog2_pow10(input int n);
    longint unsigned p;
    int              b;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    b = 0;
    while ((64'd1 << b) < p) begin
      b++;
    end
    return b;
  endfunction

endpackage

// File: rtl/xs3_to_bin_seq_if.sv
// Word-in / result-out handshake bundle for the XS3 to binary converter.
interface xs3_to_bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_xs3;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;

  // master: the environment feeding words and consuming results
  modport master (
    output in_valid, in_xs3, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  // slave: the converter itself
  modport slave (
    input  in_valid, in_xs3, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );

endinterface

// File: rtl/xs3_to_bin_seq_digit_dec.sv
// Single XS3 digit decoder: value = code - 3 (4-bit wrap), invalid for codes outside 3..12.
// Purely combinational.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [3:0] o_val,
  output logic       o_invalid
);

  assign o_val     = i_code - XS3_BIAS;
  assign o_invalid = (i_code < XS3_MIN) || (i_code > XS3_MAX);

endmodule

// File: rtl/xs3_to_bin_seq.sv
// Sequential multi-digit XS3 to binary converter, one digit per clock, MSD first; result DIGITS edges after accept.
// Result is held in DONE until out_ready; a new word may be accepted on the same edge the result is taken.
module xs3_to_bin_seq
  import xs3_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter bit CHECK_CODES = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  xs3_to_bin_seq_if.slave bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  generate
    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
      $error("xs3_to_bin_seq: DIGITS must be within 1..8");
    end
    if (BIN_W < clog2_pow10(DIGITS)) begin : g_bad_bin_w
      $error("xs3_to_bin_seq: BIN_W too narrow for DIGITS decimal digits");
    end
  endgenerate

  xs3_state_t        r_state;
  xs3_state_t        w_state_nxt;
  logic [SR_W-1:0]   r_sreg;
  logic [BIN_W-1:0]  r_acc;
  logic [BIN_W-1:0]  r_out_bin;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_out_err;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [3:0]        w_dval;
  logic              w_dinv;
  logic              w_err_nxt;
  logic [BIN_W-1:0]  w_acc_nxt;

  xs3_digit_dec u_dec (
    .i_code    (r_sreg[SR_W-1 -: 4]),
    .o_val     (w_dval),
    .o_invalid (w_dinv)
  );

  // acc*10 as (acc<<3)+(acc<<1); wraps naturally at BIN_W bits
  assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_dval);
  assign w_err_nxt = r_err | (CHECK_CODES & w_dinv);
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_load      = 1'b1;
            w_state_nxt = CONV;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_out_bin <= '0;
      r_out_err <= 1'b0;
    end else if (w_load) begin
      r_sreg <= bus.in_xs3;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_step) begin
      r_sreg <= r_sreg << 4;
      r_acc  <= w_acc_nxt;
      r_cnt  <= r_cnt + 1'b1;
      r_err  <= w_err_nxt;
      // Result registers only move on entry to DONE
      if (w_last) begin
        r_out_bin <= w_err_nxt ? '0 : w_acc_nxt;
        r_out_err <= w_err_nxt;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_xs3_to_bin_seq.sv
// Self-checking bench for xs3_to_bin_seq: directed scenarios plus exhaustive and random streams against a reference model.
module tb_xs3_to_bin_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xs3_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();
  xs3_to_bin_seq_if #(.DIGITS(4), .BIN_W(14)) bus0 ();

  xs3_to_bin_seq #(.DIGITS(4), .BIN_W(14), .CHECK_CODES(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  xs3_to_bin_seq #(.DIGITS(4), .BIN_W(14), .CHECK_CODES(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  logic [15:0] s_w[$];
  logic [13:0] o_bin[$];
  logic        o_err[$];
  int          o_cyc[$];
  int          a_cyc[$];

  // Positional decimal value of the word; each digit is (code-3) mod 16, total mod 2^14.
  function automatic void model(input logic [15:0] w, input bit chk,
                                output logic [13:0] bin, output logic err);
    int v;
    bit bad;
    v   = 0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int code;
      code = int'(w[4*i +: 4]);
      if (code < 3 || code > 12) bad = 1'b1;
      v += ((code + 13) % 16) * (10 ** i);
    end
    err = chk && bad;
    bin = err ? 14'd0 : 14'(v % 16384);
  endfunction

  // Single transaction on the checked DUT; starts and ends 1 time unit after a rising edge.
  task automatic run_word(input logic [15:0] w, output logic [13:0] bin,
                          output logic e, output int lat);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_xs3    = w;
    bus.out_ready = 1'b0;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_xs3   = 16'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    bin = bus.out_bin;
    e   = bus.out_err;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_word0(input logic [15:0] w, output logic [13:0] bin, output logic e);
    int n;
    n = 0;
    bus0.in_valid  = 1'b1;
    bus0.in_xs3    = w;
    bus0.out_ready = 1'b0;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    while (!bus0.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    bin = bus0.out_bin;
    e   = bus0.out_err;
    bus0.out_ready = 1'b1;
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
  endtask

  // Streams s_w back-to-back with out_ready held high, logging results and accept/result cycles.
  task automatic stream();
    int idx;
    int budget;
    bit fa;
    o_bin.delete(); o_err.delete(); o_cyc.delete(); a_cyc.delete();
    idx    = 0;
    budget = s_w.size() * 5 + 40;
    bus.out_ready = 1'b1;
    while ((idx < s_w.size() || o_bin.size() < s_w.size()) && budget > 0) begin
      bus.in_valid = (idx < s_w.size());
      bus.in_xs3   = (idx < s_w.size()) ? s_w[idx] : 16'h0;
      #1;
      fa = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        o_bin.push_back(bus.out_bin);
        o_err.push_back(bus.out_err);
        o_cyc.push_back(cyc);
      end
      if (fa) begin
        a_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      budget--;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.out_valid, bus.out_bin, bus.out_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b bin=%0d err=%b required 0/0/0",
               bus.out_valid, bus.out_bin, bus.out_err);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [13:0] b;
    logic        e;
    int          lat;
    run_word(16'h4567, b, e, lat);
    n_checks++;
    if (b !== 14'd1234) begin n_fail++; $display("FAIL basic_bin: got %0d required 1234", b); end
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", e); end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d edges required 4", lat); end
  endtask

  task automatic test_bounds();
    logic [13:0] b;
    logic        e;
    int          lat;
    run_word(16'h3333, b, e, lat);
    n_checks++;
    if ({e, b} !== {1'b0, 14'd0}) begin n_fail++; $display("FAIL bound_zero: got err=%b bin=%0d required 0/0", e, b); end
    run_word(16'hCCCC, b, e, lat);
    n_checks++;
    if ({e, b} !== {1'b0, 14'd9999}) begin n_fail++; $display("FAIL bound_9999: got err=%b bin=%0d required 0/9999", e, b); end
    s_w.delete();
    for (int n = 0; n < 10000; n++) begin
      s_w.push_back({4'((n / 1000) + 3), 4'(((n / 100) % 10) + 3),
                     4'(((n / 10) % 10) + 3), 4'((n % 10) + 3)});
    end
    stream();
    n_checks++;
    if (o_bin.size() !== 10000) begin
      n_fail++;
      $display("FAIL exhaustive_count: got %0d results required 10000", o_bin.size());
    end else begin
      for (int n = 0; n < 10000; n++) begin
        n_checks++;
        if ({o_err[n], o_bin[n]} !== {1'b0, 14'(n)}) begin
          n_fail++;
          $display("FAIL exhaustive_word %h: got err=%b bin=%0d required 0/%0d", s_w[n], o_err[n], o_bin[n], n);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [13:0] b, eb;
    logic        e, ee;
    int          lat;
    run_word(16'h4F67, b, e, lat);
    n_checks++;
    if ({e, b} !== {1'b1, 14'd0}) begin n_fail++; $display("FAIL err_4F67: got err=%b bin=%0d required 1/0", e, b); end
    run_word(16'h2333, b, e, lat);
    n_checks++;
    if ({e, b} !== {1'b1, 14'd0}) begin n_fail++; $display("FAIL err_2333: got err=%b bin=%0d required 1/0", e, b); end
    s_w.delete();
    for (int i = 0; i < 300; i++) s_w.push_back(16'($urandom));
    stream();
    n_checks++;
    if (o_bin.size() !== 300) begin
      n_fail++;
      $display("FAIL random_count: got %0d results required 300", o_bin.size());
    end else begin
      for (int i = 0; i < 300; i++) begin
        model(s_w[i], 1'b1, eb, ee);
        n_checks++;
        if ({o_err[i], o_bin[i]} !== {ee, eb}) begin
          n_fail++;
          $display("FAIL random_word %h: got err=%b bin=%0d required %b/%0d", s_w[i], o_err[i], o_bin[i], ee, eb);
        end
      end
    end
  endtask

  task automatic test_nocheck();
    logic [15:0] words[3];
    logic [13:0] b, eb;
    logic        e, ee;
    words = '{16'h4F67, 16'h2333, 16'h2222};
    for (int i = 0; i < 3; i++) begin
      run_word0(words[i], b, e);
      model(words[i], 1'b0, eb, ee);
      n_checks++;
      if ({e, b} !== {ee, eb}) begin
        n_fail++;
        $display("FAIL nocheck_word %h: got err=%b bin=%0d required %b/%0d", words[i], e, b, ee, eb);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_xs3    = 16'h4567;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1;
    bus.in_xs3   = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.out_valid, bus.out_err, bus.out_bin, bus.in_ready} !== {1'b1, 1'b0, 14'd1234, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got valid=%b err=%b bin=%0d in_ready=%b required 1/0/1234/0",
                 i, bus.out_valid, bus.out_err, bus.out_bin, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_release: got valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    s_w.delete();
    s_w.push_back(16'h4444);
    s_w.push_back(16'h5555);
    stream();
    n_checks++;
    if (o_bin.size() !== 2 || a_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results required 2", o_bin.size());
    end else begin
      n_checks++;
      if (o_bin[0] !== 14'd1111 || o_bin[1] !== 14'd2222) begin
        n_fail++;
        $display("FAIL b2b_values: got %0d,%0d required 1111,2222", o_bin[0], o_bin[1]);
      end
      n_checks++;
      if (o_cyc[1] - o_cyc[0] !== 5) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles required 5", o_cyc[1] - o_cyc[0]);
      end
      n_checks++;
      if (a_cyc[1] !== o_cyc[0]) begin
        n_fail++;
        $display("FAIL b2b_overlap: second accept at cycle %0d required %0d", a_cyc[1], o_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] b;
    logic        e;
    int          lat;
    bit          leaked;
    bus.in_valid  = 1'b1;
    bus.in_xs3    = 16'h4567;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_bin, bus.out_err} !== 16'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b bin=%0d err=%b required 0/0/0",
               bus.out_valid, bus.out_bin, bus.out_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b required 1", bus.in_ready); end
    leaked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin n_fail++; $display("FAIL midreset_leak: got out_valid=1 after reset required 0"); end
    run_word(16'h3334, b, e, lat);
    n_checks++;
    if ({e, b} !== {1'b0, 14'd1}) begin n_fail++; $display("FAIL midreset_next: got err=%b bin=%0d required 0/1", e, b); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_xs3     = 16'h0;
    bus.out_ready  = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_xs3    = 16'h0;
    bus0.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bounds();
    test_errors();
    test_nocheck();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
